// File: rtl/mux_scan_pkg.sv
// +----------------------------------------------------------------------------+
// | mux_scan_pkg                                                               |
// | Shared types, constants and select encoding for the mux scan controller.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package mux_scan_pkg;

    localparam int NCH   = 8;
    localparam int CHW   = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } scan_state_e;

    typedef struct packed {
        logic s3;
        logic s1;
        logic s2;
    } sel_t;

    // Channel index k is presented to the mux as {s3,s1,s2} = k.
    function automatic sel_t sel_encode(input logic [CHW-1:0] idx);
        sel_t s;
        s.s3 = idx[2];
        s.s1 = idx[1];
        s.s2 = idx[0];
        return s;
    endfunction

endpackage

`default_nettype wire

// File: rtl/scan_next_ch.sv
// +----------------------------------------------------------------------------+
// | scan_next_ch                                                               |
// | Priority finder: next enabled channel above ptr and lowest enabled one.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module scan_next_ch
    import mux_scan_pkg::*;
(
    input  logic [NCH-1:0] mask_i,
    input  logic [CHW-1:0] ptr_i,
    output logic [CHW-1:0] next_o,
    output logic           next_found_o,
    output logic [CHW-1:0] low_o,
    output logic           low_found_o
);

    // Descending walk so the last hit is the smallest qualifying index.
    always_comb begin
        next_o       = '0;
        next_found_o = 1'b0;
        low_o        = '0;
        low_found_o  = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (mask_i[i]) begin
                low_o       = CHW'(i);
                low_found_o = 1'b1;
                if (i > int'(ptr_i)) begin
                    next_o       = CHW'(i);
                    next_found_o = 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mux_scan_ctrl.sv
// +----------------------------------------------------------------------------+
// | mux_scan_ctrl                                                              |
// | Bank + select sequencer around the 8:1 mux, valid/ready word output.       |
// | Optional self-check against the bank: define MUX_SCAN_CHECK_EN.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int WIDTH = 16
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [CHW-1:0]       wr_addr,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 cont,
    input  logic [NCH-1:0]       ch_mask,
    output logic [NCH*WIDTH-1:0] bank_q,
    output logic [WIDTH-1:0]     s1_o,
    output logic [WIDTH-1:0]     s2_o,
    output logic [WIDTH-1:0]     s3_o,
    input  logic [WIDTH-1:0]     mux_y,
    output logic [WIDTH-1:0]     out_data,
    output logic [CHW-1:0]       out_chan,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 done
`ifdef MUX_SCAN_CHECK_EN
    ,
    output logic                 err
`endif
);

    scan_state_e          state_q, state_d;
    logic [CHW-1:0]       ptr_q, ptr_d;
    logic [NCH-1:0]       mask_q, mask_d;
    logic                 cont_q, cont_d;
    logic [WIDTH-1:0]     out_data_q, out_data_d;
    logic [CHW-1:0]       out_chan_q, out_chan_d;
    logic                 out_valid_q, out_valid_d;
    logic                 done_q, done_d;
    logic                 capture;
    logic [WIDTH-1:0]     bank_mem_q [NCH];

    logic [NCH-1:0]       find_mask;
    logic [CHW-1:0]       next_ch, low_ch;
    logic                 next_found, low_found;
    sel_t                 sel;

    // In IDLE the finder looks at the live mask so start can pick the first channel.
    assign find_mask = (state_q == IDLE) ? ch_mask : mask_q;

    scan_next_ch u_next (
        .mask_i       (find_mask),
        .ptr_i        (ptr_q),
        .next_o       (next_ch),
        .next_found_o (next_found),
        .low_o        (low_ch),
        .low_found_o  (low_found)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        mask_d      = mask_q;
        cont_d      = cont_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        out_valid_d = out_valid_q;
        done_d      = 1'b0;
        capture     = 1'b0;
        if (stop) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mask_d = ch_mask;
                        cont_d = cont;
                        if (low_found) begin
                            ptr_d   = low_ch;
                            state_d = SETTLE;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                SETTLE: begin
                    capture     = 1'b1;
                    out_data_d  = mux_y;
                    out_chan_d  = ptr_q;
                    out_valid_d = 1'b1;
                    state_d     = HOLD;
                end
                HOLD: begin
                    if (out_valid_q && out_ready) begin
                        out_valid_d = 1'b0;
                        if (next_found) begin
                            ptr_d   = next_ch;
                            state_d = SETTLE;
                        end else if (cont_q) begin
                            ptr_d   = low_ch;
                            state_d = SETTLE;
                        end else begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            mask_q      <= '0;
            cont_q      <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            mask_q      <= mask_d;
            cont_q      <= cont_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                bank_mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            bank_mem_q[wr_addr] <= wr_data;
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_bank
        assign bank_q[k*WIDTH +: WIDTH] = bank_mem_q[k];
    end

    // ptr only moves when entering SETTLE, so it doubles as the select register.
    assign sel       = sel_encode(ptr_q);
    assign s1_o      = {WIDTH{sel.s1}};
    assign s2_o      = {WIDTH{sel.s2}};
    assign s3_o      = {WIDTH{sel.s3}};
    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

`ifdef MUX_SCAN_CHECK_EN
    logic err_q, err_d;

    assign err_d = err_q | (capture && (mux_y != bank_mem_q[ptr_q]));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mux_scan_ctrl.sv
// +----------------------------------------------------------------------------+
// | tb_mux_scan_ctrl                                                           |
// | Scoreboard bench: directed scans, monitor pops expected words on accept.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_mux_scan_ctrl;

    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           wr_en = 1'b0;
    logic [2:0]     wr_addr = '0;
    logic [W-1:0]   wr_data = '0;
    logic           start = 1'b0;
    logic           stop = 1'b0;
    logic           cont = 1'b0;
    logic [7:0]     ch_mask = '0;
    logic [8*W-1:0] bank_q;
    logic [W-1:0]   s1_o, s2_o, s3_o;
    logic [W-1:0]   mux_y;
    logic [W-1:0]   out_data;
    logic [2:0]     out_chan;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic           busy;
    logic           done;
`ifdef MUX_SCAN_CHECK_EN
    logic           err;
`endif

    logic           force_en = 1'b0;
    logic [W-1:0]   force_val = '0;

    typedef struct {
        logic [2:0]   ch;
        logic [W-1:0] d;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   hs_cnt = 0;
    int   done_cnt = 0;

    always #5 clk = ~clk;

    mux_scan_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .start     (start),
        .stop      (stop),
        .cont      (cont),
        .ch_mask   (ch_mask),
        .bank_q    (bank_q),
        .s1_o      (s1_o),
        .s2_o      (s2_o),
        .s3_o      (s3_o),
        .mux_y     (mux_y),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
`ifdef MUX_SCAN_CHECK_EN
        ,
        .err       (err)
`endif
    );

    // Behavioural 8:1 mux standing in for the NAND mux.
    always_comb begin
        int idx;
        idx = int'({s3_o[0], s1_o[0], s2_o[0]});
        mux_y = force_en ? force_val : bank_q[idx*W +: W];
    end

    task automatic chk(input string name, input logic [8*W-1:0] act, input logic [8*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [W-1:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic push(input logic [2:0] c, input logic [W-1:0] d);
        exp_t e;
        e.ch = c; e.d = d;
        sb_q.push_back(e);
    endtask

    task automatic do_start(input logic [7:0] m, input logic c);
        ch_mask = m; cont = c; start = 1'b1;
        tick();
        start = 1'b0; cont = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk(name, {127'd0, done}, 128'd1);
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk(name, {127'd0, out_valid}, 128'd1);
    endtask

    task automatic reset_outputs_zero(input string tag);
        chk({tag, "_bank"}, bank_q, '0);
        chk({tag, "_sel"}, {80'd0, s3_o, s1_o, s2_o}, '0);
        chk({tag, "_out"}, {109'd0, out_data, out_chan}, '0);
        chk({tag, "_flags"}, {125'd0, out_valid, busy, done}, '0);
`ifdef MUX_SCAN_CHECK_EN
        chk({tag, "_err"}, {127'd0, err}, '0);
`endif
    endtask

    // Monitor: an accept is visible at the negedge before the accepting edge.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            hs_cnt++;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word actual chan=%0d data=%0h required none", out_chan, out_data);
            end else begin
                e = sb_q.pop_front();
                chk("mon_data", {112'd0, out_data}, {112'd0, e.d});
                chk("mon_chan", {125'd0, out_chan}, {125'd0, e.ch});
                chk("mon_sel", {80'd0, s3_o, s1_o, s2_o},
                    {80'd0, {W{e.ch[2]}}, {W{e.ch[1]}}, {W{e.ch[0]}}});
            end
        end
        if (!rst && done) begin
            done_cnt++;
            chk("done_busy", {127'd0, busy}, '0);
        end
    end

    initial begin
        int base, hbase, n;
        bit seen5;

        rst = 1'b1;
        #12;
        reset_outputs_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Full scan, all channels, single mode.
        for (int k = 0; k < 8; k++) wr(3'(k), W'(16'h1000 + k));
        chk("bank_write", bank_q[3*W +: W], 128'h1003);
        for (int k = 0; k < 8; k++) push(3'(k), W'(16'h1000 + k));
        out_ready = 1'b1;
        base = done_cnt;
        do_start(8'hFF, 1'b0);
        ch_mask = 8'h00;
        chk("lat_e0", {126'd0, out_valid, busy}, 128'd1);
        tick();
        chk("lat_e1", {111'd0, out_valid, out_data}, {111'd1, 16'h1000});
        wait_done("done_full");
        chk("done_state", {126'd0, busy, out_valid}, '0);
        tick();
        chk("done_width", {127'd0, done}, '0);
        chk("done_count_full", 128'(done_cnt - base), 128'd1);
        chk("sb_empty_full", 128'(sb_q.size()), '0);

        // Sparse mask, explicit select check on channel 5.
        push(3'd2, 16'h1002); push(3'd5, 16'h1005); push(3'd7, 16'h1007);
        seen5 = 1'b0;
        do_start(8'b1010_0100, 1'b0);
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            if (out_valid && out_chan == 3'd5 && !seen5) begin
                seen5 = 1'b1;
                chk("sel_ch5", {80'd0, s3_o, s1_o, s2_o}, {80'd0, 16'hFFFF, 16'h0000, 16'hFFFF});
            end
            tick();
            n++;
        end
        chk("done_sparse", {126'd0, done, seen5}, 128'd3);
        chk("sb_empty_sparse", 128'(sb_q.size()), '0);
        tick();

        // Backpressure: word frozen while out_ready is low, then delivered once.
        out_ready = 1'b0;
        push(3'd3, 16'h1003);
        do_start(8'h08, 1'b0);
        wait_valid("bp_valid");
        wr(3'd3, 16'h5555);
        for (int c = 0; c < 4; c++) begin
            chk("bp_hold", {92'd0, out_valid, out_chan, out_data, s3_o, s1_o, s2_o},
                {92'd0, 1'b1, 3'd3, 16'h1003, 16'h0000, 16'hFFFF, 16'hFFFF});
            tick();
        end
        hbase = hs_cnt;
        out_ready = 1'b1;
        wait_done("done_bp");
        tick();
        chk("bp_once", 128'(hs_cnt - hbase), 128'd1);
        wr(3'd3, 16'h1003);

        // Continuous mode 0,7,0,7,0 then stop while channel 7 is settling.
        wr(3'd0, 16'h1000);
        push(3'd0, 16'h1000); push(3'd7, 16'h1007); push(3'd0, 16'h1000);
        push(3'd7, 16'h1007); push(3'd0, 16'h1000);
        base = done_cnt;
        hbase = hs_cnt;
        do_start(8'h81, 1'b1);
        start = 1'b1;
        n = 0;
        while (hs_cnt < hbase + 5 && n < 100) begin
            tick();
            n++;
        end
        start = 1'b0;
        chk("cont_words", 128'(hs_cnt - hbase), 128'd5);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_state", {126'd0, busy, out_valid}, '0);
        chk("stop_sel", {80'd0, s3_o, s1_o, s2_o}, {80'd0, 16'hFFFF, 16'hFFFF, 16'hFFFF});
        repeat (4) tick();
        chk("stop_no_done", 128'(done_cnt - base), '0);
        chk("stop_no_more", 128'(hs_cnt - hbase), 128'd5);
        chk("sb_empty_cont", 128'(sb_q.size()), '0);

        // Empty mask: immediate done, no word.
        hbase = hs_cnt;
        do_start(8'h00, 1'b0);
        chk("empty_done", {125'd0, done, busy, out_valid}, 128'd4);
        tick();
        chk("empty_pulse", {127'd0, done}, '0);
        chk("empty_no_word", 128'(hs_cnt - hbase), '0);

        // Asynchronous reset in the middle of HOLD.
        out_ready = 1'b0;
        base = done_cnt;
        do_start(8'h04, 1'b0);
        wait_valid("rst_hold_valid");
        #2 rst = 1'b1;
        #1;
        reset_outputs_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        repeat (3) tick();
        chk("rst_no_done", 128'(done_cnt - base), '0);
        out_ready = 1'b1;

`ifdef MUX_SCAN_CHECK_EN
        // Forced mismatch on channel 3: err latches, capture still delivers.
        wr(3'd3, 16'h1003);
        push(3'd3, 16'hDEAD);
        force_val = 16'hDEAD;
        force_en = 1'b1;
        do_start(8'h08, 1'b0);
        wait_done("chk_done");
        force_en = 1'b0;
        chk("err_set", {127'd0, err}, 128'd1);
        repeat (5) tick();
        chk("err_sticky", {127'd0, err}, 128'd1);
        rst = 1'b1;
        #1;
        chk("err_clear", {127'd0, err}, '0);
        @(negedge clk);
        rst = 1'b0;
        tick();
`endif

        chk("sb_empty_end", 128'(sb_q.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
